// File: rtl/fx3_bus_reader.sv
// Burst reader for an FX3 GPIF producer: requests bursts, captures words after a fixed read latency.
// Optional test-pattern sequence checker compiled in with FX3_READER_SEQCHECK_EN.
module fx3_bus_reader #(
    parameter int BURST_WORDS  = 8192,
    parameter int READ_LATENCY = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        fx3_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        dataAvailable,
    input  logic        bufferError,
    input  logic [15:0] databus,
    output logic        collectData,
    output logic        readData,
    output logic        wordValid,
    output logic [15:0] wordOut,
    output logic [15:0] burstCount,
    output logic [15:0] errorCount,
    output logic        overflowSeen
);

    typedef enum logic [2:0] {IDLE, WAIT_AVAIL, READ, GAP, HALT} state_t;

    state_t                  state;
    logic [15:0]             rd_cnt;
    logic [15:0]             cap_cnt;
    logic [7:0]              gap_cnt;
    logic [READ_LATENCY-1:0] rd_shift;
    logic                    capture;
    logic                    last_capture;
    logic                    halt_req;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The capture window is the read strobe delayed by the producer's latency.
    assign capture      = rd_shift[READ_LATENCY-1] && (state == READ);
    assign last_capture = capture && (cap_cnt == 16'(BURST_WORDS - 1));
    assign halt_req     = bufferError && collectData;

    always_ff @(posedge fx3_clock) begin
        if (reset) begin
            state        <= IDLE;
            collectData  <= 1'b0;
            readData     <= 1'b0;
            wordValid    <= 1'b0;
            overflowSeen <= 1'b0;
            wordOut      <= 16'd0;
            burstCount   <= 16'd0;
            rd_cnt       <= 16'd0;
            cap_cnt      <= 16'd0;
            gap_cnt      <= 8'd0;
            rd_shift     <= '0;
        end else if (halt_req) begin
            state        <= HALT;
            collectData  <= 1'b0;
            readData     <= 1'b0;
            wordValid    <= 1'b0;
            overflowSeen <= 1'b1;
            rd_shift     <= '0;
        end else begin
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                rd_shift[i] <= rd_shift[i-1];
            end
            rd_shift[0] <= readData;
            wordValid   <= capture;
            if (capture) begin
                wordOut <= databus;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= WAIT_AVAIL;
                        collectData <= 1'b1;
                    end
                end
                WAIT_AVAIL: begin
                    if (!enable) begin
                        state       <= IDLE;
                        collectData <= 1'b0;
                    end else if (dataAvailable) begin
                        state    <= READ;
                        readData <= 1'b1;
                        rd_cnt   <= 16'd0;
                        cap_cnt  <= 16'd0;
                    end
                end
                READ: begin
                    if (readData) begin
                        if (rd_cnt == 16'(BURST_WORDS - 1)) begin
                            readData <= 1'b0;
                        end else begin
                            rd_cnt <= rd_cnt + 16'd1;
                        end
                    end
                    if (last_capture) begin
                        burstCount <= burstCount + 16'd1;
                        state      <= GAP;
                        gap_cnt    <= 8'd0;
                    end else if (capture) begin
                        cap_cnt <= cap_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        if (enable) begin
                            state <= WAIT_AVAIL;
                        end else begin
                            state       <= IDLE;
                            collectData <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                HALT: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FX3_READER_SEQCHECK_EN
    logic [9:0] seq_exp;
    logic       seq_locked;

    // Expected next value is always the received low bits plus one, so a bad word resyncs the checker.
    always_ff @(posedge fx3_clock) begin
        if (reset) begin
            seq_locked <= 1'b0;
            errorCount <= 16'd0;
        end else if (halt_req) begin
            seq_locked <= seq_locked;
        end else if (state == IDLE && enable) begin
            seq_locked <= 1'b0;
        end else if (capture) begin
            if (seq_locked && ((databus[15:10] != 6'd0) || (databus[9:0] != seq_exp))) begin
                errorCount <= sat_inc(errorCount);
            end
            seq_exp    <= databus[9:0] + 10'd1;
            seq_locked <= 1'b1;
        end
    end
`else
    assign errorCount = 16'd0;
`endif

endmodule

// File: tb/tb_fx3_bus_reader.sv
// Self-checking bench for fx3_bus_reader: table-driven sessions, abort/reset corner cases, randomized sessions.
`timescale 1ns/1ps
module tb_fx3_bus_reader;

    localparam int B = 16;
    localparam int L = 2;
    localparam int G = 4;

    logic        fx3_clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        dataAvailable = 1'b0;
    logic        bufferError = 1'b0;
    logic [15:0] databus = 16'hDEAD;
    logic        collectData;
    logic        readData;
    logic        wordValid;
    logic [15:0] wordOut;
    logic [15:0] burstCount;
    logic [15:0] errorCount;
    logic        overflowSeen;

    fx3_bus_reader #(.BURST_WORDS(B), .READ_LATENCY(L), .GAP_CYCLES(G)) dut (
        .fx3_clock    (fx3_clock),
        .reset        (reset),
        .enable       (enable),
        .dataAvailable(dataAvailable),
        .bufferError  (bufferError),
        .databus      (databus),
        .collectData  (collectData),
        .readData     (readData),
        .wordValid    (wordValid),
        .wordOut      (wordOut),
        .burstCount   (burstCount),
        .errorCount   (errorCount),
        .overflowSeen (overflowSeen)
    );

    always #8 fx3_clock = ~fx3_clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] stream_q[$];
    logic [15:0] sent_q[$];
    logic [15:0] sess_words[$];
    bit          mon_on = 1'b0;
    int          da_mode = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sequence-error count from the pattern rule, over one session's words.
    function automatic int seq_errors();
        int         e = 0;
        logic [9:0] ex = 10'd0;
        bit         locked = 1'b0;
        foreach (sess_words[i]) begin
            if (locked && (sess_words[i][15:10] != 6'd0 || sess_words[i][9:0] != ex)) e++;
            ex     = sess_words[i][9:0] + 10'd1;
            locked = 1'b1;
        end
        return e;
    endfunction

    initial forever begin
        @(negedge fx3_clock);
        case (da_mode)
            0:       dataAvailable = 1'b0;
            1:       dataAvailable = 1'b1;
            default: dataAvailable = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Producer model plus burst-shape monitor.
    initial begin : mon_prod
        int          cyc = 0, rise_cyc = 0, fall_cyc = 0, rd_run = 0, wv_run = 0;
        bit          rd_prev = 0, wv_prev = 0, have_fall = 0;
        logic [7:0]  rd_hist = 8'd0;
        logic [15:0] w;
        forever begin
            @(negedge fx3_clock);
            cyc++;
            if (!mon_on) begin
                have_fall = 0; rd_run = 0; wv_run = 0;
            end else begin
                if (readData === 1'b1 && !rd_prev) begin
                    if (have_fall && da_mode == 1) check("burst_spacing", cyc - fall_cyc, L + G + 1);
                    rise_cyc = cyc;
                    rd_run   = 0;
                end
                if (readData === 1'b1) rd_run++;
                if (readData !== 1'b1 && rd_prev) begin
                    check("read_len", rd_run, B);
                    fall_cyc  = cyc;
                    have_fall = 1;
                end
                if (wordValid === 1'b1 && !wv_prev) check("valid_latency", cyc - rise_cyc, L + 1);
                if (wordValid === 1'b1) begin
                    wv_run++;
                    if (sent_q.size() == 0) check("word_extra", 1, 0);
                    else check("word_value", wordOut, sent_q.pop_front());
                end
                if (wordValid !== 1'b1 && wv_prev) begin
                    check("valid_len", wv_run, B);
                    wv_run = 0;
                end
            end
            rd_prev = (readData === 1'b1);
            wv_prev = (wordValid === 1'b1);
            rd_hist = {rd_hist[6:0], readData === 1'b1};
            if (rd_hist[L]) begin
                w = (stream_q.size() > 0) ? stream_q.pop_front() : 16'hBEEF;
                sent_q.push_back(w);
                databus = w;
            end else begin
                databus = 16'hDEAD;
            end
        end
    end

    task automatic reset_dut();
        mon_on = 1'b0; enable = 1'b0; bufferError = 1'b0; reset = 1'b1;
        repeat (4) @(negedge fx3_clock);
        reset = 1'b0;
        stream_q.delete(); sent_q.delete(); sess_words.delete();
        mon_on = 1'b1;
    endtask

    task automatic push_counting(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            stream_q.push_back(16'((start + k) & 10'h3FF));
        end
    endtask

    task automatic wait_words(input int n);
        int c = 0, t = 0;
        while (c < n && t < 2000) begin
            @(negedge fx3_clock);
            t++;
            if (wordValid === 1'b1) c++;
        end
        check("wait_words", c, n);
    endtask

    task automatic run_session(input int nb, input int base);
        int t = 0;
        enable = 1'b1;
        while (!(readData === 1'b1 && burstCount == 16'(base + nb - 1)) && t < 5000) begin
            @(negedge fx3_clock);
            t++;
        end
        check("last_burst_start", t < 5000, 1);
        enable = 1'b0;
        t = 0;
        while (collectData !== 1'b0 && t < 500) begin
            @(negedge fx3_clock);
            t++;
        end
        check("session_end", t < 500, 1);
    endtask

    typedef struct {
        int start;
        int nb;
        int bad_idx;
        int bad_val;
        int err_chk;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   n, act, err_exp, base, nb;
        logic [15:0] w;

        vecs[0] = '{0,    1, -1, 0,      0};
        vecs[1] = '{1008, 2, -1, 0,      0};
        vecs[2] = '{0,    1, 5,  16'h0400, 2};
        vecs[3] = '{100,  2, 17, 16'h0123, 2};
        vecs[4] = '{500,  3, -1, 0,      0};

        reset = 1'b1;
        repeat (3) @(negedge fx3_clock);
        check("rst_collectData", collectData, 0);
        check("rst_readData", readData, 0);
        check("rst_wordValid", wordValid, 0);
        check("rst_overflowSeen", overflowSeen, 0);
        check("rst_wordOut", wordOut, 0);
        check("rst_burstCount", burstCount, 0);
        check("rst_errorCount", errorCount, 0);

        da_mode = 1;
        for (int i = 0; i < 5; i++) begin
            reset_dut();
            for (int k = 0; k < vecs[i].nb * B; k++) begin
                w = 16'((vecs[i].start + k) & 10'h3FF);
                if (k == vecs[i].bad_idx) w = 16'(vecs[i].bad_val);
                stream_q.push_back(w);
            end
            run_session(vecs[i].nb, 0);
            check("vec_burstCount", burstCount, vecs[i].nb);
`ifdef FX3_READER_SEQCHECK_EN
            check("vec_errorCount", errorCount, vecs[i].err_chk);
`else
            check("vec_errorCount", errorCount, 0);
`endif
            check("vec_words_left", stream_q.size() + sent_q.size(), 0);
        end

        // enable dropped mid-burst: burst completes, gap, then idle
        reset_dut();
        push_counting(0, B);
        enable = 1'b1;
        wait_words(3);
        enable = 1'b0;
        n = 0;
        while (collectData !== 1'b0 && n < 100) begin
            @(negedge fx3_clock);
            n++;
        end
        check("drop_enable_cycles", n, B + G - 3);
        check("drop_enable_bursts", burstCount, 1);
        act = 0;
        repeat (10) begin
            @(negedge fx3_clock);
            if (readData === 1'b1 || collectData === 1'b1) act++;
        end
        check("drop_enable_quiet", act, 0);

        // overflow mid-burst: halt until reset
        reset_dut();
        mon_on = 1'b0;
        push_counting(0, 2 * B);
        enable = 1'b1;
        wait_words(8);
        bufferError = 1'b1;
        @(negedge fx3_clock);
        bufferError = 1'b0;
        check("halt_overflowSeen", overflowSeen, 1);
        check("halt_readData", readData, 0);
        check("halt_collectData", collectData, 0);
        check("halt_wordValid", wordValid, 0);
        check("halt_burstCount", burstCount, 0);
        act = 0;
        repeat (40) begin
            @(negedge fx3_clock);
            if (readData === 1'b1 || collectData === 1'b1 || wordValid === 1'b1) act++;
        end
        check("halt_held", act, 0);
        check("halt_sticky", overflowSeen, 1);
        reset_dut();
        check("halt_cleared", overflowSeen, 0);

        // overflow coinciding with the last captured word
        mon_on = 1'b0;
        push_counting(0, 2 * B);
        enable = 1'b1;
        wait_words(B - 1);
        bufferError = 1'b1;
        @(negedge fx3_clock);
        bufferError = 1'b0;
        check("last_halt_burstCount", burstCount, 0);
        check("last_halt_overflowSeen", overflowSeen, 1);
        check("last_halt_wordValid", wordValid, 0);

        // bufferError outside collection is ignored
        reset_dut();
        bufferError = 1'b1;
        repeat (3) @(negedge fx3_clock);
        bufferError = 1'b0;
        check("idle_err_ignored", overflowSeen, 0);
        push_counting(0, B);
        run_session(1, 0);
        check("idle_err_burst", burstCount, 1);
        check("idle_err_overflow", overflowSeen, 0);

        // reset mid-burst, then a clean burst
        reset_dut();
        mon_on = 1'b0;
        push_counting(0, 2 * B);
        enable = 1'b1;
        wait_words(10);
        reset = 1'b1;
        @(negedge fx3_clock);
        check("midrst_outputs", {collectData, readData, wordValid, overflowSeen}, 0);
        check("midrst_wordOut", wordOut, 0);
        check("midrst_burstCount", burstCount, 0);
        reset_dut();
        push_counting(300, B);
        run_session(1, 0);
        check("midrst_rerun_bursts", burstCount, 1);
        check("midrst_rerun_errors", errorCount, 0);

        // randomized sessions against the pattern-rule model
        reset_dut();
        da_mode = 2;
        base = 0;
        err_exp = 0;
        for (int s = 0; s < 6; s++) begin
            nb = $urandom_range(1, 3);
            n  = $urandom_range(0, 1023);
            sess_words.delete();
            for (int k = 0; k < nb * B; k++) begin
                w = 16'((n + k) & 10'h3FF);
                if ($urandom_range(0, 19) == 0) w = 16'($urandom_range(0, 65535));
                sess_words.push_back(w);
                stream_q.push_back(w);
            end
`ifdef FX3_READER_SEQCHECK_EN
            err_exp += seq_errors();
`endif
            run_session(nb, base);
            base += nb;
            check("rand_burstCount", burstCount, base);
            check("rand_errorCount", errorCount, err_exp);
            check("rand_words_left", stream_q.size() + sent_q.size(), 0);
            repeat ($urandom_range(1, 5)) @(negedge fx3_clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fx3_bus_reader.md
FX3_BUS_READER -- requirements
Module: fx3_bus_reader

Interface
REQ-001 Parameter BURST_WORDS, default 8192, words read per burst (range 2..65535).
REQ-002 Parameter READ_LATENCY, default 2, fx3_clock cycles from readData rising edge to first valid databus word (range 1..7).
REQ-003 Parameter GAP_CYCLES, default 4, idle cycles after each burst before dataAvailable is sampled again (range 1..255).
REQ-004 fx3_clock  input  1  60 MHz GPIF clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = run capture session; 0 = stop after the current burst.
REQ-007 dataAvailable  input  1  producer has at least BURST_WORDS words buffered.
REQ-008 bufferError  input  1  producer overflow flag.
REQ-009 databus  input  16  producer data word.
REQ-010 collectData  output  1  requests producer to collect samples.
REQ-011 readData  output  1  burst read strobe to producer.
REQ-012 wordValid  output  1  wordOut holds a captured word this cycle.
REQ-013 wordOut  output  16  registered captured word.
REQ-014 burstCount  output  16  completed bursts, wraps 0xFFFF->0.
REQ-015 errorCount  output  16  sequence errors, saturates at 0xFFFF.
REQ-016 overflowSeen  output  1  sticky; bufferError seen while collecting.

Function
REQ-017 States: IDLE, WAIT_AVAIL, READ, GAP, HALT.
REQ-018 IDLE: collectData=0, readData=0; enable=1 -> WAIT_AVAIL with collectData=1 from the next cycle.
REQ-019 WAIT_AVAIL: enable=0 -> IDLE; else dataAvailable=1 -> READ, with readData=1 from the next cycle.
REQ-020 READ: readData held 1 for exactly BURST_WORDS consecutive cycles, then 0.
REQ-021 Capture window opens READ_LATENCY cycles after the readData rising edge and lasts exactly BURST_WORDS cycles; each databus word is registered to wordOut with wordValid=1 one cycle after sampling.
REQ-022 Last captured word -> burstCount+1 and GAP; GAP lasts GAP_CYCLES, then WAIT_AVAIL if enable=1, else IDLE.
REQ-023 enable falling during READ or GAP does not truncate the burst; collectData drops on entry to IDLE.
REQ-024 bufferError=1 while collectData=1 -> overflowSeen=1 and HALT next cycle, regardless of state; HALT aborts any burst (readData=0, collectData=0, wordValid=0, no burstCount increment) and is left only by reset.
REQ-025 bufferError with collectData=0 is ignored.
REQ-026 dataAvailable is not sampled in READ or GAP.
REQ-027 Simultaneous bufferError and last captured word: HALT wins, burstCount not incremented.

Reset
REQ-028 reset=1 on a clock edge -> IDLE; collectData, readData, wordValid, overflowSeen = 0; wordOut, burstCount, errorCount = 0; checker unlocked.
REQ-029 reset overrides every state, including mid-burst; no partial burst is counted.

Configuration
REQ-030 Macro FX3_READER_SEQCHECK_EN defined: test-pattern checker compiled in; each captured word must have [15:10]=0 and [9:0] = previous [9:0]+1 mod 1024; first word after IDLE->WAIT_AVAIL only loads the expectation; each mismatch increments errorCount and reloads the expectation from the received word; the expectation carries across bursts within a session.
REQ-031 Macro undefined: no checker logic; errorCount constant 0.

Verification
REQ-032 BURST_WORDS=16, READ_LATENCY=2; enable=1, dataAvailable=1, counting pattern 0,1,2.. -> readData high 16 cycles, 16 wordValid pulses starting 3 cycles after readData rise, burstCount=1, errorCount=0.
REQ-033 Pattern 1021,1022,1023,0,1 across a burst boundary -> errorCount=0 (wrap legal).
REQ-034 SEQCHECK_EN, word 5 replaced by 0x0400 -> errorCount=2 (bad upper bits, then mismatched resync); undefined -> errorCount=0.
REQ-035 bufferError pulsed at word 8 of a burst -> overflowSeen=1, readData and collectData 0 next cycle, burstCount unchanged, state held until reset.
REQ-036 enable dropped at word 3 -> burst completes 16 words, GAP 4 cycles, IDLE, collectData=0, burstCount=1.
REQ-037 reset asserted at word 10 -> all outputs 0 next cycle; re-enable gives a clean full burst, burstCount=1.
